// File: rtl/cpu_pkg.sv
// Shared definitions for the stack CPU: opcodes, sequencer phases and parameter defaults.
package cpu_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned DepthDefault = 16;
  localparam int unsigned PcWDefault   = 10;
  localparam int unsigned AddrWDefault = 8;

  typedef enum logic [7:0] {
    OpNop  = 8'h00,
    OpPush = 8'h01,
    OpOut  = 8'h02,
    OpAdd  = 8'h03,
    OpSub  = 8'h04,
    OpMul  = 8'h05,
    OpSt   = 8'h06,
    OpLd   = 8'h07,
    OpDup  = 8'h08,
    OpDrop = 8'h09,
    OpJmp  = 8'h0A,
    OpJz   = 8'h0B,
    OpJnz  = 8'h0C,
    OpHalt = 8'hFF
  } opcode_e;

  typedef enum logic [2:0] {
    StExec,
    StAddr,
    StMem,
    StPcupd,
    StHalt,
    StFault
  } phase_e;

  // Unassigned opcodes fold onto NOP so the core never sees an illegal value.
  function automatic opcode_e decode_op(input logic [7:0] raw);
    opcode_e op;
    case (raw)
      8'h01:   op = OpPush;
      8'h02:   op = OpOut;
      8'h03:   op = OpAdd;
      8'h04:   op = OpSub;
      8'h05:   op = OpMul;
      8'h06:   op = OpSt;
      8'h07:   op = OpLd;
      8'h08:   op = OpDup;
      8'h09:   op = OpDrop;
      8'h0A:   op = OpJmp;
      8'h0B:   op = OpJz;
      8'h0C:   op = OpJnz;
      8'hFF:   op = OpHalt;
      default: op = OpNop;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_stack.sv
// Operand stack storage: push, pop, or replace-top-two (pop two, push one) per cycle.
module cpu_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       replace,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          top,
  output logic [DATA_W-1:0]          next,
  output logic [$clog2(DEPTH+1)-1:0] sp
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned SpW  = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [SpW-1:0]    sp_q;
  logic [IdxW-1:0]   idx_push;
  logic [IdxW-1:0]   idx_top;
  logic [IdxW-1:0]   idx_next;

  always_comb begin
    idx_push = IdxW'(sp_q);
    idx_top  = IdxW'(sp_q - SpW'(1));
    idx_next = IdxW'(sp_q - SpW'(2));
  end

  assign top  = mem_q[idx_top];
  assign next = mem_q[idx_next];
  assign sp   = sp_q;

  // Entry contents are don't-care until written, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[idx_push] <= wdata;
    end else if (replace) begin
      mem_q[idx_next] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + SpW'(1);
    end else if (pop || replace) begin
      sp_q <= sp_q - SpW'(1);
    end
  end

endmodule

// File: rtl/stack_cpu.sv
// Four-phase stack CPU: EXEC decodes and checks, ADDR/MEM drive data memory and the
// stack, PCUPD advances pc. HALT and FAULT are terminal until reset.
module stack_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned PC_W   = PcWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                insn,
  output logic [PC_W-1:0]            pc,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_wr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          reg0,
  output logic                       reg0_wr,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       halted,
  output logic [1:0]                 fault
);

  localparam int unsigned SpW = $clog2(DEPTH+1);

  phase_e            state_q, state_d;
  opcode_e           op_in, op_q;
  logic [7:0]        opnd_q;
  logic              take_q;
  logic [PC_W-1:0]   pc_q, pc_next;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] reg0_q;
  logic              reg0_wr_q;
  logic [1:0]        fault_q;

  logic              need_two, need_one, need_room;
  logic              uf, of;

  logic              stk_push, stk_pop, stk_replace;
  logic [DATA_W-1:0] stk_wdata, stk_top, stk_next;
  logic [SpW-1:0]    stk_sp;

  cpu_stack #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (stk_push),
    .pop     (stk_pop),
    .replace (stk_replace),
    .wdata   (stk_wdata),
    .top     (stk_top),
    .next    (stk_next),
    .sp      (stk_sp)
  );

  // Precondition check on the live instruction; DUP reports underflow before overflow.
  always_comb begin
    op_in     = decode_op(insn[15:8]);
    need_two  = (op_in == OpAdd) || (op_in == OpSub) || (op_in == OpMul);
    need_one  = (op_in == OpOut) || (op_in == OpSt) || (op_in == OpDup) ||
                (op_in == OpDrop) || (op_in == OpJz) || (op_in == OpJnz);
    need_room = (op_in == OpPush) || (op_in == OpLd) || (op_in == OpDup);
    uf        = (need_two && (stk_sp < SpW'(2))) || (need_one && (stk_sp == '0));
    of        = !uf && need_room && (stk_sp == SpW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StExec;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StExec: begin
        if (op_in == OpHalt) begin
          state_d = StHalt;
        end else if (uf || of) begin
          state_d = StFault;
        end else begin
          state_d = StAddr;
        end
      end
      StAddr:  state_d = StMem;
      StMem:   state_d = StPcupd;
      StPcupd: state_d = StExec;
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StExec;
    endcase
  end

  always_comb begin
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_replace = 1'b0;
    stk_wdata   = '0;
    if (state_q == StMem) begin
      case (op_q)
        OpPush: begin
          stk_push  = 1'b1;
          stk_wdata = DATA_W'(opnd_q);
        end
        OpLd: begin
          stk_push  = 1'b1;
          stk_wdata = rd_data;
        end
        OpDup: begin
          stk_push  = 1'b1;
          stk_wdata = stk_top;
        end
        OpAdd: begin
          stk_replace = 1'b1;
          stk_wdata   = stk_next + stk_top;
        end
        OpSub: begin
          stk_replace = 1'b1;
          stk_wdata   = stk_next - stk_top;
        end
        OpMul: begin
          stk_replace = 1'b1;
          stk_wdata   = stk_next * stk_top;
        end
        OpSt, OpDrop, OpJz, OpJnz: stk_pop = 1'b1;
        default: ;
      endcase
    end

    case (op_q)
      OpJmp:       pc_next = PC_W'(opnd_q);
      OpJz, OpJnz: pc_next = take_q ? PC_W'(opnd_q) : pc_q + PC_W'(1);
      default:     pc_next = pc_q + PC_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OpNop;
      opnd_q     <= '0;
      take_q     <= 1'b0;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      wr_data_q  <= '0;
      reg0_q     <= '0;
      reg0_wr_q  <= 1'b0;
      fault_q    <= '0;
    end else begin
      case (state_q)
        StExec: begin
          op_q       <= op_in;
          opnd_q     <= insn[7:0];
          mem_addr_q <= ADDR_W'(insn[7:0]);
          if (op_in != OpHalt) begin
            if (uf || of) begin
              fault_q <= {of, uf};
            end else if (op_in == OpOut) begin
              reg0_q    <= stk_top;
              reg0_wr_q <= 1'b1;
            end
          end
        end
        StAddr: begin
          reg0_wr_q <= 1'b0;
          if (op_q == OpSt) begin
            mem_wr_q  <= 1'b1;
            wr_data_q <= stk_top;
          end
        end
        StMem: begin
          mem_wr_q <= 1'b0;
          take_q   <= (op_q == OpJz) ? (stk_top == '0) : (stk_top != '0);
        end
        StPcupd: pc_q <= pc_next;
        default: ;
      endcase
    end
  end

  assign pc       = pc_q;
  assign mem_addr = mem_addr_q;
  assign mem_wr   = mem_wr_q;
  assign wr_data  = wr_data_q;
  assign reg0     = reg0_q;
  assign reg0_wr  = reg0_wr_q;
  assign sp       = stk_sp;
  assign halted   = (state_q == StHalt);
  assign fault    = fault_q;

endmodule

// File: tb/tb_stack_cpu.sv
// Directed bench for stack_cpu: an instruction table plus hand-written reset, fault and halt cases.
module tb_stack_cpu;

  logic        clk;
  logic        rst;
  logic [15:0] insn;
  logic [9:0]  pc;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic [7:0]  reg0;
  logic        reg0_wr;
  logic [4:0]  sp;
  logic        halted;
  logic [1:0]  fault;

  int total = 0;
  int bad   = 0;

  int          mwc  = 0;
  int          r0c  = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  logic [7:0]  last_wr_data = 8'h00;
  logic [7:0]  dmem [256] = '{default: 8'h00};

  stack_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .insn     (insn),
    .pc       (pc),
    .mem_addr (mem_addr),
    .mem_wr   (mem_wr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .reg0     (reg0),
    .reg0_wr  (reg0_wr),
    .sp       (sp),
    .halted   (halted),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with one-cycle registered read; also counts write and reg0 strobe cycles.
  always @(posedge clk) begin
    rd_data <= dmem[mem_addr];
    if (mem_wr) begin
      dmem[mem_addr] <= wr_data;
      mwc            <= mwc + 1;
      last_wr_addr   <= mem_addr;
      last_wr_data   <= wr_data;
    end
    if (reg0_wr) r0c <= r0c + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] i);
    insn = i;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst  = 1'b1;
    insn = 16'h0000;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"}, 32'(pc), 32'h0);
    check({tag, " sp"}, 32'(sp), 32'h0);
    check({tag, " reg0"}, 32'(reg0), 32'h0);
    check({tag, " reg0_wr"}, 32'(reg0_wr), 32'h0);
    check({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
    check({tag, " wr_data"}, 32'(wr_data), 32'h0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, " halted"}, 32'(halted), 32'h0);
    check({tag, " fault"}, 32'(fault), 32'h0);
  endtask

  typedef struct {
    logic [15:0] insn;
    logic [9:0]  pc;
    logic [4:0]  sp;
    logic [7:0]  reg0;
    int          r0c;
    int          mwc;
  } vec_t;

  vec_t vecs[26];

  initial begin
    int mwc_snap;
    int r0c_snap;

    vecs[0]  = '{16'h0103, 10'h001, 5'd1, 8'h00, 0, 0};  // PUSH 3
    vecs[1]  = '{16'h0104, 10'h002, 5'd2, 8'h00, 0, 0};  // PUSH 4
    vecs[2]  = '{16'h0300, 10'h003, 5'd1, 8'h00, 0, 0};  // ADD -> 7
    vecs[3]  = '{16'h0200, 10'h004, 5'd1, 8'h07, 1, 0};  // OUT
    vecs[4]  = '{16'h0900, 10'h005, 5'd0, 8'h07, 1, 0};  // DROP
    vecs[5]  = '{16'h0105, 10'h006, 5'd1, 8'h07, 1, 0};  // PUSH 5
    vecs[6]  = '{16'h0610, 10'h007, 5'd0, 8'h07, 1, 1};  // ST 0x10
    vecs[7]  = '{16'h0710, 10'h008, 5'd1, 8'h07, 1, 1};  // LD 0x10 -> 5
    vecs[8]  = '{16'h0105, 10'h009, 5'd2, 8'h07, 1, 1};  // PUSH 5
    vecs[9]  = '{16'h0400, 10'h00A, 5'd1, 8'h07, 1, 1};  // SUB -> 0
    vecs[10] = '{16'h0B20, 10'h020, 5'd0, 8'h07, 1, 1};  // JZ 0x20 taken
    vecs[11] = '{16'h01FF, 10'h021, 5'd1, 8'h07, 1, 1};  // PUSH 0xFF
    vecs[12] = '{16'h0102, 10'h022, 5'd2, 8'h07, 1, 1};  // PUSH 2
    vecs[13] = '{16'h0500, 10'h023, 5'd1, 8'h07, 1, 1};  // MUL -> 0xFE
    vecs[14] = '{16'h0200, 10'h024, 5'd1, 8'hFE, 2, 1};  // OUT
    vecs[15] = '{16'h0800, 10'h025, 5'd2, 8'hFE, 2, 1};  // DUP
    vecs[16] = '{16'h0C40, 10'h040, 5'd1, 8'hFE, 2, 1};  // JNZ 0x40 taken
    vecs[17] = '{16'h0101, 10'h041, 5'd2, 8'hFE, 2, 1};  // PUSH 1
    vecs[18] = '{16'h0400, 10'h042, 5'd1, 8'hFE, 2, 1};  // SUB -> 0xFD
    vecs[19] = '{16'h0200, 10'h043, 5'd1, 8'hFD, 3, 1};  // OUT
    vecs[20] = '{16'h0100, 10'h044, 5'd2, 8'hFD, 3, 1};  // PUSH 0
    vecs[21] = '{16'h0C80, 10'h045, 5'd1, 8'hFD, 3, 1};  // JNZ 0x80 not taken
    vecs[22] = '{16'h0AFF, 10'h0FF, 5'd1, 8'hFD, 3, 1};  // JMP 0xFF
    vecs[23] = '{16'h0000, 10'h100, 5'd1, 8'hFD, 3, 1};  // NOP
    vecs[24] = '{16'h5512, 10'h101, 5'd1, 8'hFD, 3, 1};  // unknown opcode
    vecs[25] = '{16'h0200, 10'h102, 5'd1, 8'hFD, 4, 1};  // OUT

    rst  = 1'b0;
    insn = 16'h0000;
    #12;
    check_reset_values("reset");
    rst = 1'b1;

    // Table: each entry is one full four-phase instruction.
    for (int k = 0; k < 26; k++) begin
      step(vecs[k].insn);
      check($sformatf("v%0d pc", k), 32'(pc), 32'(vecs[k].pc));
      check($sformatf("v%0d sp", k), 32'(sp), 32'(vecs[k].sp));
      check($sformatf("v%0d reg0", k), 32'(reg0), 32'(vecs[k].reg0));
      check($sformatf("v%0d reg0_wr_cycles", k), 32'(r0c), 32'(vecs[k].r0c));
      check($sformatf("v%0d mem_wr_cycles", k), 32'(mwc), 32'(vecs[k].mwc));
      check($sformatf("v%0d fault", k), 32'(fault), 32'h0);
    end
    check("st addr", 32'(last_wr_addr), 32'h10);
    check("st data", 32'(last_wr_data), 32'h05);
    check("dmem 0x10", 32'(dmem[8'h10]), 32'h05);

    // HALT: terminal, pc frozen, later instructions ignored.
    insn = 16'hFF00;
    @(posedge clk);
    #1;
    check("halt halted", 32'(halted), 32'h1);
    check("halt pc", 32'(pc), 32'h102);
    mwc_snap = mwc;
    r0c_snap = r0c;
    insn = 16'h0200;
    repeat (20) @(posedge clk);
    #1;
    check("halt pc held", 32'(pc), 32'h102);
    check("halt sp held", 32'(sp), 32'h1);
    check("halt still", 32'(halted), 32'h1);
    check("halt no reg0_wr", 32'(r0c), 32'(r0c_snap));
    check("halt no mem_wr", 32'(mwc), 32'(mwc_snap));

    // Reset during the MEM cycle of ST aborts the write.
    do_reset();
    check_reset_values("rst2");
    step(16'h0109);
    insn = 16'h0630;
    repeat (2) @(posedge clk);
    #1;
    check("st mem phase wr", 32'(mem_wr), 32'h1);
    check("st mem phase addr", 32'(mem_addr), 32'h30);
    mwc_snap = mwc;
    #2;
    rst = 1'b0;
    #1;
    check("async rst mem_wr", 32'(mem_wr), 32'h0);
    check_reset_values("rst_mid");
    @(negedge clk);
    rst  = 1'b1;
    check("aborted st no write", 32'(mwc), 32'(mwc_snap));
    check("aborted st dmem", 32'(dmem[8'h30]), 32'h00);
    step(16'h0101);
    check("restart pc", 32'(pc), 32'h1);
    check("restart sp", 32'(sp), 32'h1);

    // ADD with a single entry underflows.
    do_reset();
    step(16'h0101);
    mwc_snap = mwc;
    insn = 16'h0300;
    @(posedge clk);
    #1;
    check("uf fault", 32'(fault), 32'h1);
    repeat (8) @(posedge clk);
    #1;
    check("uf sp", 32'(sp), 32'h1);
    check("uf pc", 32'(pc), 32'h1);
    check("uf no mem_wr", 32'(mwc), 32'(mwc_snap));
    check("uf not halted", 32'(halted), 32'h0);

    // Seventeenth PUSH overflows a 16-deep stack.
    do_reset();
    for (int k = 0; k < 16; k++) step(16'h0100 | 16'(k));
    check("of pre sp", 32'(sp), 32'd16);
    check("of pre fault", 32'(fault), 32'h0);
    insn = 16'h01AA;
    @(posedge clk);
    #1;
    check("of fault", 32'(fault), 32'h2);
    check("of sp", 32'(sp), 32'd16);
    check("of pc", 32'(pc), 32'd16);
    repeat (10) @(posedge clk);
    #1;
    check("of pc frozen", 32'(pc), 32'd16);
    check("of sp frozen", 32'(sp), 32'd16);
    check("of fault held", 32'(fault), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_cpu.md
STACK_CPU -- requirements
Module: stack_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stack word and data-bus width.
REQ-002 SHALL have parameter DEPTH, default 16, stack entries (power of two, >=2).
REQ-003 SHALL have parameter PC_W, default 10, program counter width.
REQ-004 SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port insn  input  16  instruction at pc: opcode [15:8], operand [7:0].
REQ-008 SHALL have port pc  output  PC_W  instruction address.
REQ-009 SHALL have port mem_addr  output  ADDR_W  registered data address.
REQ-010 SHALL have ports mem_wr  output  1,  wr_data  output  DATA_W,  rd_data  input  DATA_W  for data memory.
REQ-011 SHALL have ports reg0  output  DATA_W  and  reg0_wr  output  1  for the output register.
REQ-012 SHALL have ports sp  output  $clog2(DEPTH+1)  stack occupancy;  halted  output  1;  fault  output  2  ({overflow, underflow}).

Function
REQ-013 SHALL sequence each instruction through four phases, EXEC->ADDR->MEM->PCUPD->EXEC, one cycle each, plus terminal states HALT and FAULT.
REQ-014 SHALL support opcodes: 00 NOP, 01 PUSH imm, 02 OUT, 03 ADD, 04 SUB, 05 MUL, 06 ST, 07 LD, 08 DUP, 09 DROP, 0A JMP, 0B JZ, 0C JNZ, FF HALT; any other opcode executes as NOP.
REQ-015 SHALL zero-extend the 8-bit operand to DATA_W (immediates), ADDR_W (addresses) and PC_W (jump targets).
REQ-016 SHALL check stack preconditions in EXEC: ADD/SUB/MUL need sp>=2; OUT/ST/DUP/DROP/JZ/JNZ need sp>=1; PUSH/LD/DUP need room (DUP: sp<DEPTH after its operand check).
REQ-017 SHALL on precondition failure set the matching fault bit at end of EXEC, enter FAULT, and suppress all stack, memory, reg0 and pc side effects of that instruction.
REQ-018 SHALL on opcode FF enter HALT at end of EXEC with pc unchanged and halted=1.
REQ-019 SHALL remain in HALT or FAULT until reset; insn ignored; mem_wr and reg0_wr held 0.
REQ-020 SHALL register mem_addr=operand at end of EXEC for every instruction.
REQ-021 SHALL for ST assert mem_wr for exactly the MEM cycle with wr_data = top of stack, and pop at end of MEM.
REQ-022 SHALL for LD sample rd_data at end of MEM (one-cycle read latency from ADDR) and push it.
REQ-023 SHALL for OUT load reg0 with top of stack (no pop) at end of EXEC and pulse reg0_wr high for the ADDR cycle only.
REQ-024 SHALL for ADD/SUB/MUL replace the top two entries with next OP top (SUB = next minus top), modulo 2^DATA_W; MUL keeps low DATA_W bits.
REQ-025 SHALL apply all stack updates at end of MEM; sp changes by exactly +1, -1 or 0 per instruction.
REQ-026 SHALL at end of PCUPD load pc with target for JMP, for JZ if popped value ==0, for JNZ if !=0, else pc+1 modulo 2^PC_W; JZ/JNZ pop at end of MEM.
REQ-027 SHALL not expose stack entries at index >=sp; contents of unused entries are don't-care.

Reset
REQ-028 SHALL on rst low asynchronously set phase=EXEC, pc=0, sp=0, reg0=0, reg0_wr=0, mem_wr=0, wr_data=0, mem_addr=0, halted=0, fault=0.
REQ-029 SHALL abort any in-flight instruction on reset with no further memory write; stack contents need no reset.

Structure
REQ-030 SHALL place opcode enum, phase/state enum and parameter defaults in shared package cpu_pkg.
REQ-031 SHALL implement stack storage as sub-module cpu_stack (push/pop/replace ports, sp, DEPTH/DATA_W parameters).

Verification
REQ-032 SHALL verify: PUSH 3, PUSH 4, ADD, OUT -> reg0=7, reg0_wr one cycle, pc=4 after 16 cycles.
REQ-033 SHALL verify: PUSH 5, ST 0x10, LD 0x10, PUSH 5, SUB, JZ 0x20 -> mem_wr once at addr 0x10 data 5, pc=0x20, sp=0.
REQ-034 SHALL verify: DEPTH=16, 17 PUSHes -> fault=2'b10 at end of 17th EXEC, sp=16, pc=16 frozen.
REQ-035 SHALL verify: ADD with sp=1 -> fault=2'b01, sp=1, no mem_wr, pc frozen.
REQ-036 SHALL verify: PUSH 0xFF, PUSH 2, MUL (DATA_W=8) -> top=0xFE; then HALT -> halted=1, pc constant for 20 cycles.
REQ-037 SHALL verify: reset asserted during MEM of ST -> mem_wr low within reset, all REQ-028 values, restart from pc=0.
